// File: rtl/gpr_wb_ctrl.sv
// gpr_wb_ctrl: GPR write-port arbiter. The main writeback stage always owns the
// port; results from the secondary source queue in a small FIFO and drain into
// idle port cycles. A per-register pending scoreboard tracks outstanding
// secondary results so decode can stall on them.
module gpr_wb_ctrl #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_en,
    input  logic [4:0]  wb_dst,
    input  logic [31:0] wb_data,
    input  logic [31:0] wb_pc,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_dst,
    input  logic [31:0] aux_data,
    input  logic [31:0] aux_pc,
    input  logic        aux_issue,
    input  logic [4:0]  aux_issue_dst,
    output logic        WriteEnable,
    output logic [4:0]  pos3,
    output logic [31:0] WData,
    output logic [31:0] pc,
    output logic [31:0] pending,
    output logic        err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [4:0]  dst;
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     pending_q, pending_d;
    logic            err_q, err_d;

    entry_t          head;
    logic            main_live;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            issue_live;
    logic            issue_released;

    // Handshake and arbitration terms; main writes are ignored while in reset
    always_comb begin
        head           = mem_q[rd_ptr_q];
        main_live      = wb_en && (wb_dst != 5'd0) && !reset;
        fifo_empty     = (count_q == CW'(0));
        aux_ready      = (count_q < CW'(DEPTH));
        push           = aux_valid && aux_ready && (aux_dst != 5'd0);
        pop            = !main_live && !fifo_empty;
        issue_live     = aux_issue && (aux_issue_dst != 5'd0);
        issue_released = pop && (head.dst == aux_issue_dst);
    end

    // Write-port mux: main slot first, then FIFO head, else idle zeros
    always_comb begin
        WriteEnable = 1'b0;
        pos3        = 5'd0;
        WData       = 32'd0;
        pc          = 32'd0;
        if (main_live) begin
            WriteEnable = 1'b1;
            pos3        = wb_dst;
            WData       = wb_data;
            pc          = wb_pc;
        end else if (pop) begin
            WriteEnable = 1'b1;
            pos3        = head.dst;
            WData       = head.data;
            pc          = head.pc;
        end
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Scoreboard: pop clears, issue sets (set wins); sticky protocol error
    always_comb begin
        pending_d = pending_q;
        err_d     = err_q;
        if (pop) begin
            pending_d[head.dst] = 1'b0;
        end
        if (issue_live) begin
            pending_d[aux_issue_dst] = 1'b1;
        end
        pending_d[0] = 1'b0;
        if (issue_live && pending_q[aux_issue_dst] && !issue_released) begin
            err_d = 1'b1;
        end
        if (main_live && pending_q[wb_dst]) begin
            err_d = 1'b1;
        end
        if (push && !pending_q[aux_dst]) begin
            err_d = 1'b1;
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    // FIFO storage; contents are only meaningful under the count
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{dst: aux_dst, data: aux_data, pc: aux_pc};
        end
    end

    assign pending = pending_q;
    assign err     = err_q;

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Scoreboard bench for gpr_wb_ctrl: stimulus queues the expected GPR writes,
// a negedge monitor checks every write the DUT presents against that queue.
module tb_gpr_wb_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_dst = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] wb_pc = '0;
    logic        aux_valid = 1'b0;
    logic        aux_ready;
    logic [4:0]  aux_dst = '0;
    logic [31:0] aux_data = '0;
    logic [31:0] aux_pc = '0;
    logic        aux_issue = 1'b0;
    logic [4:0]  aux_issue_dst = '0;
    logic        WriteEnable;
    logic [4:0]  pos3;
    logic [31:0] WData;
    logic [31:0] pc;
    logic [31:0] pending;
    logic        err;

    typedef struct {
        logic [4:0]  dst;
        logic [31:0] data;
        logic [31:0] pc;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    gpr_wb_ctrl #(.DEPTH(2), .CW(2)) dut (
        .clk(clk), .reset(reset),
        .wb_en(wb_en), .wb_dst(wb_dst), .wb_data(wb_data), .wb_pc(wb_pc),
        .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_dst(aux_dst),
        .aux_data(aux_data), .aux_pc(aux_pc),
        .aux_issue(aux_issue), .aux_issue_dst(aux_issue_dst),
        .WriteEnable(WriteEnable), .pos3(pos3), .WData(WData), .pc(pc),
        .pending(pending), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] d, input logic [31:0] data, input logic [31:0] p);
        wr_t e;
        e.dst = d; e.data = data; e.pc = p;
        exp_q.push_back(e);
    endtask

    task automatic drive_wb(input logic en, input logic [4:0] d, input logic [31:0] data, input logic [31:0] p);
        wb_en = en; wb_dst = d; wb_data = data; wb_pc = p;
    endtask

    task automatic drive_aux(input logic v, input logic [4:0] d, input logic [31:0] data, input logic [31:0] p);
        aux_valid = v; aux_dst = d; aux_data = data; aux_pc = p;
    endtask

    task automatic idle();
        drive_wb(1'b0, 5'd0, 32'd0, 32'd0);
        drive_aux(1'b0, 5'd0, 32'd0, 32'd0);
        aux_issue = 1'b0; aux_issue_dst = 5'd0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Monitor: every presented write must match the head of the expected queue
    always @(negedge clk) begin
        if (WriteEnable) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got $%0d=%h pc=%h expected no write at %0t",
                         pos3, WData, pc, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_dst", 32'(pos3), 32'(e.dst));
                chk("wr_data", WData, e.data);
                chk("wr_pc", pc, e.pc);
            end
        end
    end

    initial begin
        // Reset state; main write offered during reset must be ignored
        drive_wb(1'b1, 5'd5, 32'hFFFF, 32'h4);
        repeat (2) step();
        chk("rst_we", 32'(WriteEnable), 32'd0);
        chk("rst_pos3", 32'(pos3), 32'd0);
        chk("rst_wdata", WData, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(aux_ready), 32'd1);
        idle();
        reset = 1'b0;
        step();

        // Main priority over a same-cycle secondary transfer
        aux_issue = 1'b1; aux_issue_dst = 5'd7;
        step();
        aux_issue = 1'b0;
        chk("prio_pending_set", pending, 32'h0000_0080);
        drive_wb(1'b1, 5'd5, 32'h1234, 32'h100);
        drive_aux(1'b1, 5'd7, 32'hBEEF, 32'h200);
        expect_wr(5'd5, 32'h1234, 32'h100);
        step();
        idle();
        expect_wr(5'd7, 32'hBEEF, 32'h200);
        chk("prio_pending_hold", pending, 32'h0000_0080);
        step();
        chk("prio_pending_clr", pending, 32'd0);
        chk("prio_err", 32'(err), 32'd0);

        // Full boundary, stall, ordering and pointer wrap
        aux_issue = 1'b1; aux_issue_dst = 5'd8; step();
        aux_issue_dst = 5'd9; step();
        aux_issue_dst = 5'd10; step();
        aux_issue = 1'b0;
        chk("full_pending", pending, 32'h0000_0700);
        drive_wb(1'b1, 5'd1, 32'h11, 32'h111);
        drive_aux(1'b1, 5'd8, 32'hA, 32'h208);
        expect_wr(5'd1, 32'h11, 32'h111);
        step();
        drive_wb(1'b1, 5'd1, 32'h12, 32'h112);
        drive_aux(1'b1, 5'd9, 32'hB, 32'h209);
        expect_wr(5'd1, 32'h12, 32'h112);
        step();
        chk("full_ready_lo", 32'(aux_ready), 32'd0);
        drive_wb(1'b1, 5'd1, 32'h13, 32'h113);
        drive_aux(1'b1, 5'd10, 32'hC, 32'h20A);
        expect_wr(5'd1, 32'h13, 32'h113);
        step();
        chk("full_ready_stall", 32'(aux_ready), 32'd0);
        drive_wb(1'b0, 5'd0, 32'd0, 32'd0);
        expect_wr(5'd8, 32'hA, 32'h208);
        step();
        chk("full_ready_after_pop", 32'(aux_ready), 32'd1);
        expect_wr(5'd9, 32'hB, 32'h209);
        step();
        drive_aux(1'b0, 5'd0, 32'd0, 32'd0);
        expect_wr(5'd10, 32'hC, 32'h20A);
        step();
        chk("full_pending_clr", pending, 32'd0);
        chk("full_err", 32'(err), 32'd0);
        chk("full_ready_empty", 32'(aux_ready), 32'd1);

        // Register $0 handling
        aux_issue = 1'b1; aux_issue_dst = 5'd3; step();
        aux_issue = 1'b0;
        drive_aux(1'b1, 5'd3, 32'h33, 32'h303);
        step();
        drive_aux(1'b0, 5'd0, 32'd0, 32'd0);
        drive_wb(1'b1, 5'd0, 32'hDEAD, 32'h999);
        expect_wr(5'd3, 32'h33, 32'h303);
        step();
        drive_wb(1'b0, 5'd0, 32'd0, 32'd0);
        drive_aux(1'b1, 5'd0, 32'h44, 32'h404);
        step();
        drive_aux(1'b0, 5'd0, 32'd0, 32'd0);
        chk("r0_ready", 32'(aux_ready), 32'd1);
        chk("r0_err", 32'(err), 32'd0);
        step();
        chk("r0_pending", pending, 32'd0);

        // Set-wins race on the same register
        aux_issue = 1'b1; aux_issue_dst = 5'd4; step();
        aux_issue = 1'b0;
        drive_aux(1'b1, 5'd4, 32'h44, 32'h404);
        step();
        drive_aux(1'b0, 5'd0, 32'd0, 32'd0);
        aux_issue = 1'b1; aux_issue_dst = 5'd4;
        expect_wr(5'd4, 32'h44, 32'h404);
        step();
        aux_issue = 1'b0;
        chk("race_pending", pending, 32'h0000_0010);
        chk("race_err", 32'(err), 32'd0);

        // Main write to a pending register: flagged, but still written
        aux_issue = 1'b1; aux_issue_dst = 5'd6; step();
        aux_issue = 1'b0;
        chk("mainpend_err_pre", 32'(err), 32'd0);
        chk("mainpend_pending", pending, 32'h0000_0050);
        drive_wb(1'b1, 5'd6, 32'h66, 32'h606);
        expect_wr(5'd6, 32'h66, 32'h606);
        step();
        drive_wb(1'b0, 5'd0, 32'd0, 32'd0);
        chk("mainpend_err", 32'(err), 32'd1);
        chk("mainpend_pending_kept", pending, 32'h0000_0050);

        // Push to a register that was never issued
        do_reset();
        chk("rst2_err", 32'(err), 32'd0);
        chk("rst2_pending", pending, 32'd0);
        drive_aux(1'b1, 5'd11, 32'hB1, 32'hB0B);
        step();
        drive_aux(1'b0, 5'd0, 32'd0, 32'd0);
        expect_wr(5'd11, 32'hB1, 32'hB0B);
        step();
        chk("nopend_push_err", 32'(err), 32'd1);

        // Duplicate issue to a pending register; sticky error
        do_reset();
        aux_issue = 1'b1; aux_issue_dst = 5'd6;
        step();
        chk("dup_err_pre", 32'(err), 32'd0);
        step();
        aux_issue = 1'b0;
        chk("dup_err", 32'(err), 32'd1);
        repeat (3) step();
        chk("dup_err_sticky", 32'(err), 32'd1);

        // Asynchronous reset with two entries buffered and pending = 0x104
        do_reset();
        aux_issue = 1'b1; aux_issue_dst = 5'd2; step();
        aux_issue_dst = 5'd8; step();
        aux_issue = 1'b0;
        drive_wb(1'b1, 5'd1, 32'h21, 32'h121);
        drive_aux(1'b1, 5'd2, 32'h2222, 32'h202);
        expect_wr(5'd1, 32'h21, 32'h121);
        step();
        drive_wb(1'b1, 5'd1, 32'h22, 32'h122);
        drive_aux(1'b1, 5'd8, 32'h8888, 32'h208);
        expect_wr(5'd1, 32'h22, 32'h122);
        step();
        drive_aux(1'b0, 5'd0, 32'd0, 32'd0);
        drive_wb(1'b1, 5'd1, 32'h23, 32'h123);
        chk("arst_pending_pre", pending, 32'h0000_0104);
        chk("arst_ready_pre", 32'(aux_ready), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_we", 32'(WriteEnable), 32'd0);
        chk("arst_pos3", 32'(pos3), 32'd0);
        chk("arst_wdata", WData, 32'd0);
        chk("arst_pc", pc, 32'd0);
        chk("arst_pending", pending, 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_ready", 32'(aux_ready), 32'd1);
        step();
        step();
        reset = 1'b0;
        drive_wb(1'b0, 5'd0, 32'd0, 32'd0);
        chk("arst_ready_post", 32'(aux_ready), 32'd1);
        chk("arst_we_post", 32'(WriteEnable), 32'd0);
        repeat (3) step();
        chk("arst_pending_post", pending, 32'd0);

        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
